// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: holds PCF, drives imem, delivers InstrD/PCD/PCPlus4D/ValidD.
// Latency: instruction fetched at PCF in cycle N appears in InstrD in cycle N+1.
// Backpressure: StallF/StallD hold state, imem_rvalid=0 holds PCF and inserts a bubble.
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  logic [31:0] pcPlus4F;
  logic [31:0] redirectPc;

  // Sequential PC increment wraps naturally at 2^32; redirect targets are word aligned.
  assign pcPlus4F   = PCF + 32'd4;
  assign redirectPc = {PCTargetE[31:2], 2'b00};

  // Fetch request is live in every cycle outside reset; address is the current PC.
  assign imem_req  = ~rst;
  assign imem_addr = PCF;

  // PC register: redirect beats stall, stall beats memory wait, else advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PCF <= RESET_VECTOR;
    end else if (PCSrcE) begin
      PCF <= redirectPc;
    end else if (StallF || !imem_rvalid) begin
      PCF <= PCF;
    end else begin
      PCF <= pcPlus4F;
    end
  end

  // IF/ID register: flush (or wrong-path squash) beats stall, stall beats a memory-wait bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (FlushD || PCSrcE) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (StallD) begin
      InstrD <= InstrD;
      ValidD <= ValidD;
    end else if (!imem_rvalid) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else begin
      InstrD   <= imem_rdata;
      PCD      <= PCF;
      PCPlus4D <= pcPlus4F;
      ValidD   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction-memory model.
// Latency: expected IF/ID contents queued before each edge, compared after it.
// Backpressure: stalls, memory waits, flushes and redirects driven explicitly.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        valid;
  } dExp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int checks   = 0;
  int failures = 0;
  dExp_t scoreQ[$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_rdata(imem_rdata),
    .imem_rvalid(imem_rvalid), .imem_addr(imem_addr), .imem_req(imem_req),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a known encoding at 0, address-tagged words elsewhere.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'd0) return 32'h0010_0093;
    return {8'hA5, a[23:0]};
  endfunction

  assign imem_rdata = memWord(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // StallD without StallF must never be driven.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      assert (!(StallD && !StallF)) else begin
        failures++;
        $error("FAIL illegal_stall got=%b%b exp=not_01", StallF, StallD);
      end
    end
  end

  task automatic setIn(input logic sf, input logic sd, input logic fd, input logic ps,
                       input logic [31:0] tgt, input logic rv);
    StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt; imem_rvalid = rv;
  endtask

  // One clock: queue expected IF/ID result, take the edge, pop and compare.
  task automatic doCycle(input string tag, input logic [31:0] expPc, input logic [31:0] eInstr,
                         input logic [31:0] ePc, input logic [31:0] ePc4, input logic eValid);
    dExp_t e;
    scoreQ.push_back('{instr: eInstr, pc: ePc, pcPlus4: ePc4, valid: eValid});
    @(posedge clk);
    #1;
    e = scoreQ.pop_front();
    chk({tag, ".PCF"},      PCF,           expPc);
    chk({tag, ".addr"},     imem_addr,     expPc);
    chk({tag, ".InstrD"},   InstrD,        e.instr);
    chk({tag, ".PCD"},      PCD,           e.pc);
    chk({tag, ".PCPlus4D"}, PCPlus4D,      e.pcPlus4);
    chk({tag, ".ValidD"},   {31'd0, ValidD}, {31'd0, e.valid});
  endtask

  task automatic chkReset(input string tag);
    chk({tag, ".PCF"},      PCF,      32'd0);
    chk({tag, ".InstrD"},   InstrD,   NOP);
    chk({tag, ".PCD"},      PCD,      32'd0);
    chk({tag, ".PCPlus4D"}, PCPlus4D, 32'd0);
    chk({tag, ".ValidD"},   {31'd0, ValidD},   32'd0);
    chk({tag, ".req"},      {31'd0, imem_req}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    setIn(0, 0, 0, 0, 32'd0, 1);
    #2;
    chkReset("rst0");
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("req_after_rst", {31'd0, imem_req}, 32'd1);

    // First fetch after reset release.
    doCycle("first",  32'd4, 32'h0010_0093, 32'd0, 32'd4, 1);
    doCycle("seq4",   32'd8, memWord(32'd4), 32'd4, 32'd8, 1);

    // Load-use style stall for two cycles at PCF=8, then release.
    setIn(1, 1, 0, 0, 32'd0, 1);
    doCycle("stall1", 32'd8, memWord(32'd4), 32'd4, 32'd8, 1);
    doCycle("stall2", 32'd8, memWord(32'd4), 32'd4, 32'd8, 1);
    setIn(0, 0, 0, 0, 32'd0, 1);
    doCycle("unstall", 32'd12, memWord(32'd8), 32'd8, 32'd12, 1);

    // Redirect beats stall; unaligned target is word aligned.
    setIn(1, 1, 0, 1, 32'h0000_0103, 1);
    doCycle("redir_stall", 32'h100, NOP, 32'd8, 32'd12, 0);
    setIn(0, 0, 0, 0, 32'd0, 1);
    doCycle("redir_tgt", 32'h104, memWord(32'h100), 32'h100, 32'h104, 1);

    // Plain redirect to 0x20 squashes the wrong-path fetch.
    setIn(0, 0, 0, 1, 32'h20, 1);
    doCycle("redir20", 32'h20, NOP, 32'h100, 32'h104, 0);

    // Three memory-wait cycles at 0x20, then the fetch completes.
    setIn(0, 0, 0, 0, 32'd0, 0);
    for (int i = 0; i < 3; i++) doCycle("wait", 32'h20, NOP, 32'h100, 32'h104, 0);
    setIn(0, 0, 0, 0, 32'd0, 1);
    doCycle("wait_done", 32'h24, memWord(32'h20), 32'h20, 32'h24, 1);

    // Memory wait during StallD: IF/ID holds instead of bubbling.
    setIn(1, 1, 0, 0, 32'd0, 0);
    doCycle("wait_stall", 32'h24, memWord(32'h20), 32'h20, 32'h24, 1);

    // FlushD overrides StallD.
    setIn(1, 1, 1, 0, 32'd0, 1);
    doCycle("flush_stall", 32'h24, NOP, 32'h20, 32'h24, 0);

    // Wrap-around at the top of the address space.
    setIn(0, 0, 0, 1, 32'hFFFF_FFFF, 1);
    doCycle("redir_top", 32'hFFFF_FFFC, NOP, 32'h20, 32'h24, 0);
    setIn(0, 0, 0, 0, 32'd0, 1);
    doCycle("wrap", 32'd0, memWord(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'd0, 1);
    doCycle("after_wrap", 32'd4, 32'h0010_0093, 32'd0, 32'd4, 1);

    // Reach PCF=0x40 with a valid instruction in Decode, then reset asynchronously.
    setIn(0, 0, 0, 1, 32'h3C, 1);
    doCycle("redir3c", 32'h3C, NOP, 32'd0, 32'd4, 0);
    setIn(0, 0, 0, 0, 32'd0, 1);
    doCycle("pre_rst", 32'h40, memWord(32'h3C), 32'h3C, 32'h40, 1);
    #2;
    rst = 1'b1;
    #1;
    chkReset("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    doCycle("post_rst", 32'd4, 32'h0010_0093, 32'd0, 32'd4, 1);

    chk("queue_empty", scoreQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage plus IF/ID pipeline register of the 5-stage RV32I pipeline.
- Holds the program counter and drives the instruction-memory read.
- Applies redirects from Execute (PCSrcE, PCTargetE).
- Honours the hazard unit's StallF, StallD and FlushD.
- Delivers InstrD/PCD/PCPlus4D/ValidD to Decode.
- Absorbs instruction-memory wait cycles by inserting bubbles into Decode.

Parameters:
RESET_VECTOR, 32'h0000_0000, PCF value loaded on reset
NOP_INSTR, 32'h0000_0013, encoding (addi x0,x0,0) written into InstrD on flush/bubble

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
StallF  input  1  hold PCF (from hazard unit)
StallD  input  1  hold IF/ID register (from hazard unit)
FlushD  input  1  clear IF/ID register to NOP (from hazard unit)
PCSrcE  input  1  taken branch/jump resolved in Execute
PCTargetE  input  32  redirect target from Execute
imem_rdata  input  32  instruction at imem_addr, same-cycle combinational
imem_rvalid  input  1  imem_rdata valid this cycle; 0 = memory wait
imem_addr  output  32  equals PCF
imem_req  output  1  fetch request
PCF  output  32  current fetch PC
InstrD  output  32  instruction to Decode
PCD  output  32  PC of InstrD
PCPlus4D  output  32  PCD + 4
ValidD  output  1  InstrD is a real instruction (0 = bubble)

Behaviour:
Interface (already decided):
- One clock, clk.
- Reset rst is asynchronous and active-high.

Reset (asynchronous, immediate on rst=1, regardless of clk):
- PCF = RESET_VECTOR; InstrD = NOP_INSTR; PCD = 0; PCPlus4D = 0; ValidD = 0.
- imem_req = 0 while rst = 1.
- First request is issued in the first cycle after rst deasserts.
- Reset asserted mid-operation discards all in-flight state identically.

imem_req and imem_addr:
- imem_req = 1 in every non-reset cycle.
- imem_addr = PCF, combinational.

PC register, next-state priority, highest first:
1. PCSrcE=1: PCF <= {PCTargetE[31:2],2'b00}. Overrides StallF and a memory wait; low two bits are always cleared.
2. StallF=1: hold PCF.
3. imem_rvalid=0: hold PCF (same address re-requested).
4. Otherwise: PCF <= PCF + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).

IF/ID register, priority highest first:
1. FlushD=1 or PCSrcE=1: InstrD <= NOP_INSTR, ValidD <= 0; PCD and PCPlus4D hold. FlushD overrides StallD.
2. StallD=1: hold all four outputs.
3. imem_rvalid=0: InstrD <= NOP_INSTR, ValidD <= 0; PCD and PCPlus4D hold.
4. Otherwise: InstrD <= imem_rdata; PCD <= PCF; PCPlus4D <= PCF + 4 (wraps); ValidD <= 1.

Latency:
- An instruction fetched at PCF in cycle N appears in InstrD in cycle N+1.
- After a redirect in cycle N, the target is fetched in N+1 and decoded in N+2.
- This gives a two-bubble branch penalty together with FlushE.

Illegal combination:
- StallD=1 with StallF=0 is illegal.
- The bench asserts it never occurs; no behaviour is defined for it.

Simultaneous events:
- StallF=1, StallD=1, PCSrcE=1: PC redirects and IF/ID flushes. Branch beats load-use stall.
- imem_rvalid=0 during StallD=1: IF/ID holds; the stall has priority over the bubble.

Test Plan:
- Reset release, RESET_VECTOR=0, imem_rvalid=1, imem returns 32'h0010_0093 at 0 → cycle 1: PCF=4, InstrD=32'h0010_0093, PCD=0, PCPlus4D=4, ValidD=1.
- Hold StallF=StallD=1 for 2 cycles at PCF=8 → PCF stays 8, InstrD/PCD unchanged, ValidD unchanged; on release PCF goes to 12 next edge.
- PCSrcE=1, PCTargetE=32'h0000_0103 with StallF=StallD=1 → next edge PCF=32'h100, InstrD=32'h13, ValidD=0; following edge PCD=32'h100, ValidD=1.
- imem_rvalid=0 for 3 cycles at PCF=32'h20 → PCF stays 32'h20, InstrD=NOP, ValidD=0 for 3 cycles; then PCD=32'h20, ValidD=1.
- PCF=32'hFFFF_FFFC, no stalls → next PCF=0, PCPlus4D=0, PCD=32'hFFFF_FFFC.
- rst pulsed between clock edges while ValidD=1, PCF=32'h40 → outputs go to reset values immediately, no clock edge needed; PCF=RESET_VECTOR, ValidD=0, imem_req=0.
